resv_issue_sched: RTL and testbench

RESV_ISSUE_SCHED -- requirements
Module: resv_issue_sched

---
 rtl/resv_issue_sched_pkg.sv | 27 ++
 rtl/resv_pipe_timer.sv | 25 ++
 rtl/resv_issue_sched.sv | 96 +++++++++
 tb/tb_resv_issue_sched.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/resv_issue_sched_pkg.sv
// Shared types and constants for the reservation-station issue scheduler.
// Holds the FSM encoding, the "no candidate" uop marker and default widths.
package resv_issue_sched_pkg;

  localparam int DEF_W_IDENT   = 4;
  localparam int DEF_W_PD_UOPS = 6;
  localparam int DEF_W_LAT     = 3;
  localparam int DEF_W_CNT     = 16;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH1 = 2'd1,
    FLUSH2 = 2'd2
  } sched_state_e;

  // All-ones uop means the picker found no ready candidate for that pipe.
  localparam logic [DEF_W_PD_UOPS-1:0] unused_op = '1;

  // Single-issue arbitration: bit0 = pipe 1, bit1 = pipe 2, never both.
  function automatic logic [1:0] pick_pipe(input logic elig1,
                                           input logic elig2,
                                           input logic odr);
    if (elig1 && elig2) return odr ? 2'b10 : 2'b01;
    return {elig2, elig1};
  endfunction

endpackage

// File: rtl/resv_pipe_timer.sv
// Per-pipe busy counter: loads the issued uop's extra latency, then counts
// down to zero; the pipe may accept a new uop only when the count is zero.
module resv_pipe_timer
  import resv_issue_sched_pkg::*;
#(
  parameter int W_LAT = DEF_W_LAT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             issue,
  input  logic [W_LAT-1:0] lat,
  output logic [W_LAT-1:0] cnt
);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt <= '0;
    else if (flush)         cnt <= '0;
    else if (issue)         cnt <= lat;
    else if (cnt != '0)     cnt <= cnt - W_LAT'(1);
  end

endmodule

// File: rtl/resv_issue_sched.sv
// Issue scheduler for a two-pipe reservation station: picks at most one
// ready uop per cycle, gates decode insertion and sequences pipeline flushes.
module resv_issue_sched
  import resv_issue_sched_pkg::*;
#(
  parameter int W_ident   = DEF_W_IDENT,
  parameter int W_PD_UOPS = DEF_W_PD_UOPS,
  parameter int W_LAT     = DEF_W_LAT,
  parameter int W_CNT     = DEF_W_CNT
) (
  input  logic                 clk,
  input  logic                 CFI_PC_rst,
  input  logic                 CFI_PC_clear,
  input  logic                 DFI_PV_dec,
  input  logic                 CFI_PC_full,
  input  logic [W_PD_UOPS-1:0] CDI_PD_uops1,
  input  logic [W_PD_UOPS-1:0] CDI_PD_uops2,
  input  logic                 CDI_PD_odr,
  input  logic [W_LAT-1:0]     CDI_PD_lat1,
  input  logic [W_LAT-1:0]     CDI_PD_lat2,
  input  logic                 CFI_PC_busy1,
  input  logic                 CFI_PC_busy2,
  output logic [1:0]           CDO_PC_s1,
  output logic                 CDO_PC_ena,
  output logic                 CDO_PC_stall,
  output logic                 CFO_PC_clear,
  output logic [W_CNT-1:0]     CDO_PD_icnt
);

  if (W_ident < 1) begin : g_param_check
    $error("W_ident must be at least 1");
  end

  localparam logic [W_PD_UOPS-1:0] NO_CAND = {W_PD_UOPS{unused_op[0]}};

  sched_state_e     state, state_nxt;
  logic [W_LAT-1:0] cnt1, cnt2;
  logic             issue_ok, elig1, elig2;

  always_ff @(posedge clk or posedge CFI_PC_rst) begin
    if (CFI_PC_rst) state <= FLUSH1;
    else            state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     state_nxt = RUN;
      FLUSH1:  state_nxt = FLUSH2;
      FLUSH2:  state_nxt = RUN;
      default: state_nxt = FLUSH1;
    endcase
    if (CFI_PC_clear) state_nxt = FLUSH1;
  end

  // A flush request suppresses issue in the very cycle it is raised.
  assign issue_ok = (state == RUN) && !CFI_PC_clear;
  assign elig1    = issue_ok && (CDI_PD_uops1 != NO_CAND) && (cnt1 == '0) && !CFI_PC_busy1;
  assign elig2    = issue_ok && (CDI_PD_uops2 != NO_CAND) && (cnt2 == '0) && !CFI_PC_busy2;

  always_comb begin
    CDO_PC_s1    = pick_pipe(elig1, elig2, CDI_PD_odr);
    CDO_PC_ena   = issue_ok && DFI_PV_dec && (!CFI_PC_full || (CDO_PC_s1 != 2'b00));
    CDO_PC_stall = 1'b1;
    if (state == RUN)
      CDO_PC_stall = DFI_PV_dec && CFI_PC_full && (CDO_PC_s1 == 2'b00);
    CFO_PC_clear = (state == FLUSH1);
  end

  resv_pipe_timer #(.W_LAT(W_LAT)) u_timer1 (
    .clk   (clk),
    .rst   (CFI_PC_rst),
    .flush (CFI_PC_clear),
    .issue (CDO_PC_s1[0]),
    .lat   (CDI_PD_lat1),
    .cnt   (cnt1)
  );

  resv_pipe_timer #(.W_LAT(W_LAT)) u_timer2 (
    .clk   (clk),
    .rst   (CFI_PC_rst),
    .flush (CFI_PC_clear),
    .issue (CDO_PC_s1[1]),
    .lat   (CDI_PD_lat2),
    .cnt   (cnt2)
  );

  // Issue count survives flushes; only reset clears it.
  always_ff @(posedge clk or posedge CFI_PC_rst) begin
    if (CFI_PC_rst)              CDO_PD_icnt <= '0;
    else if (CDO_PC_s1 != 2'b00) CDO_PD_icnt <= CDO_PD_icnt + W_CNT'(1);
  end

endmodule

// File: tb/tb_resv_issue_sched.sv
// Self-checking bench for resv_issue_sched: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_resv_issue_sched;

  localparam int W_PD_UOPS = 6;
  localparam int W_LAT     = 3;
  localparam int W_CNT     = 16;
  localparam logic [W_PD_UOPS-1:0] NO_OP = '1;

  logic                 clk = 1'b0;
  logic                 rst, clear, dec, full, odr, busy1, busy2;
  logic [W_PD_UOPS-1:0] uops1, uops2;
  logic [W_LAT-1:0]     lat1, lat2;
  logic [1:0]           s1;
  logic                 ena, stall, clear_o;
  logic [W_CNT-1:0]     icnt;

  always #5 clk = ~clk;

  resv_issue_sched dut (
    .clk          (clk),
    .CFI_PC_rst   (rst),
    .CFI_PC_clear (clear),
    .DFI_PV_dec   (dec),
    .CFI_PC_full  (full),
    .CDI_PD_uops1 (uops1),
    .CDI_PD_uops2 (uops2),
    .CDI_PD_odr   (odr),
    .CDI_PD_lat1  (lat1),
    .CDI_PD_lat2  (lat2),
    .CFI_PC_busy1 (busy1),
    .CFI_PC_busy2 (busy2),
    .CDO_PC_s1    (s1),
    .CDO_PC_ena   (ena),
    .CDO_PC_stall (stall),
    .CFO_PC_clear (clear_o),
    .CDO_PD_icnt  (icnt)
  );

  int tests = 0;
  int fails = 0;

  // Model: cycles of flush still to run (2 = first flush cycle), busy
  // cycles remaining per pipe, and the running issue total.
  int         flush_left;
  int         busy_cnt [2];
  int         m_icnt;
  logic [1:0] exp_s1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    flush_left  = 2;
    busy_cnt[0] = 0;
    busy_cnt[1] = 0;
    m_icnt      = 0;
  endtask

  // Let combinational outputs settle, then compare every output to the model.
  task automatic settle();
    bit run, e1, e2, exp_ena, exp_stall;
    #1;
    if (rst) model_reset();
    run = (flush_left == 0) && !rst && !clear;
    e1  = run && (uops1 != NO_OP) && (busy_cnt[0] == 0) && !busy1;
    e2  = run && (uops2 != NO_OP) && (busy_cnt[1] == 0) && !busy2;
    if (e1 && e2) exp_s1 = odr ? 2'b10 : 2'b01;
    else          exp_s1 = {e2, e1};
    exp_ena   = run && dec && (!full || exp_s1 != 2'b00);
    exp_stall = (flush_left != 0) ? 1'b1 : (dec && full && exp_s1 == 2'b00);
    check("model_s1",    32'(s1),      32'(exp_s1));
    check("model_ena",   32'(ena),     32'(exp_ena));
    check("model_stall", 32'(stall),   32'(exp_stall));
    check("model_clear", 32'(clear_o), 32'(flush_left == 2));
    check("model_icnt",  32'(icnt),    32'(m_icnt));
  endtask

  task automatic advance();
    @(posedge clk);
    if (!rst) begin
      if (exp_s1 != 2'b00) m_icnt = (m_icnt + 1) % (1 << W_CNT);
      if (clear) begin
        flush_left  = 2;
        busy_cnt[0] = 0;
        busy_cnt[1] = 0;
      end else begin
        if (flush_left > 0) flush_left--;
        for (int k = 0; k < 2; k++) begin
          if (exp_s1[k])            busy_cnt[k] = (k == 0) ? int'(lat1) : int'(lat2);
          else if (busy_cnt[k] > 0) busy_cnt[k]--;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic set_idle();
    clear = 1'b0; dec = 1'b0; full = 1'b0; odr = 1'b0;
    busy1 = 1'b0; busy2 = 1'b0;
    uops1 = NO_OP; uops2 = NO_OP;
    lat1  = '0;    lat2  = '0;
  endtask

  initial begin
    rst = 1'b1;
    set_idle();
    model_reset();
    dec = 1'b1; uops1 = 6'h01;
    @(negedge clk);

    // Held in reset: flush outputs even with a candidate and decode valid.
    settle();
    check("rst_s1", 32'(s1), 32'd0);
    check("rst_ena", 32'(ena), 32'd0);
    check("rst_stall", 32'(stall), 32'd1);
    check("rst_clear", 32'(clear_o), 32'd1);
    check("rst_icnt", 32'(icnt), 32'd0);
    advance(); settle(); advance();

    // Release: cycle 0 FLUSH1, cycle 1 FLUSH2, cycle 2 RUN.
    rst = 1'b0;
    set_idle();
    settle();
    check("rel_c0_clear", 32'(clear_o), 32'd1);
    check("rel_c0_stall", 32'(stall), 32'd1);
    advance(); settle();
    check("rel_c1_clear", 32'(clear_o), 32'd0);
    check("rel_c1_stall", 32'(stall), 32'd1);
    advance(); settle();
    check("rel_c2_stall", 32'(stall), 32'd0);
    check("rel_c2_icnt", 32'(icnt), 32'd0);
    advance();

    // Arbitration between two ready candidates.
    uops1 = 6'h02; uops2 = 6'h05; odr = 1'b1;
    settle();
    check("arb_odr1_s1", 32'(s1), 32'b10);
    advance();
    odr = 1'b0;
    settle();
    check("arb_icnt", 32'(icnt), 32'd1);
    check("arb_odr0_s1", 32'(s1), 32'b01);
    advance();

    // Latency: pipe 1 blocked for three cycles after a lat=3 issue.
    uops2 = NO_OP; lat1 = 3'd3;
    settle();
    check("lat_issue_s1", 32'(s1), 32'b01);
    advance();
    uops2 = 6'h05; lat1 = '0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("lat_blocked_s1", 32'(s1), 32'b10);
      advance();
    end
    settle();
    check("lat_free_s1", 32'(s1), 32'b01);
    advance();

    // Station full.
    uops1 = NO_OP; uops2 = NO_OP; full = 1'b1; dec = 1'b1;
    settle();
    check("full_stall", 32'(stall), 32'd1);
    check("full_ena", 32'(ena), 32'd0);
    advance();
    uops1 = 6'h04;
    settle();
    check("full_issue_ena", 32'(ena), 32'd1);
    check("full_issue_stall", 32'(stall), 32'd0);
    advance();
    full = 1'b0;

    // Flush while pipe 1 is busy.
    uops1 = 6'h01; lat1 = 3'd3; dec = 1'b0;
    settle(); advance();
    lat1 = '0;
    settle(); advance();
    check("flush_pre_cnt", 32'(dut.u_timer1.cnt), 32'd2);
    uops2 = 6'h05; clear = 1'b1; dec = 1'b1;
    settle();
    check("flush_same_s1", 32'(s1), 32'd0);
    check("flush_same_ena", 32'(ena), 32'd0);
    advance();
    clear = 1'b0;
    settle();
    check("flush_f1_clear", 32'(clear_o), 32'd1);
    check("flush_f1_stall", 32'(stall), 32'd1);
    check("flush_f1_cnt1", 32'(dut.u_timer1.cnt), 32'd0);
    check("flush_f1_cnt2", 32'(dut.u_timer2.cnt), 32'd0);
    advance(); settle();
    check("flush_f2_clear", 32'(clear_o), 32'd0);
    check("flush_f2_stall", 32'(stall), 32'd1);
    check("flush_f2_s1", 32'(s1), 32'd0);
    advance(); settle();
    check("flush_run_stall", 32'(stall), 32'd0);
    check("flush_run_s1", 32'(s1), 32'b01);
    advance();

    // Reset arriving mid-cycle while an issue is being presented.
    uops2 = NO_OP; lat1 = 3'd5;
    settle(); advance();
    uops2 = 6'h05; lat1 = '0;
    settle();
    check("midrst_pre_s1", 32'(s1), 32'b10);
    rst = 1'b1;
    settle();
    check("midrst_s1", 32'(s1), 32'd0);
    check("midrst_icnt", 32'(icnt), 32'd0);
    check("midrst_cnt1", 32'(dut.u_timer1.cnt), 32'd0);
    advance();
    rst = 1'b0;
    settle(); advance(); settle(); advance();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      uops1 = ($urandom_range(3) == 0) ? NO_OP : W_PD_UOPS'($urandom);
      uops2 = ($urandom_range(3) == 0) ? NO_OP : W_PD_UOPS'($urandom);
      lat1  = W_LAT'($urandom);
      lat2  = W_LAT'($urandom);
      odr   = 1'($urandom);
      dec   = 1'($urandom);
      full  = 1'($urandom);
      busy1 = ($urandom_range(4) == 0);
      busy2 = ($urandom_range(4) == 0);
      clear = ($urandom_range(39) == 0);
      rst   = ($urandom_range(299) == 0);
      settle();
      advance();
    end
    rst = 1'b0;
    set_idle();
    settle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
